// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 poll controller and receiver.
package dht11_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      START,
      WAIT,
      CHECK,
      FAIL
   } state_t;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_RX  = 2'b01;
   localparam logic [1:0] ERR_CRC = 2'b10;
   localparam logic [1:0] ERR_TMO = 2'b11;

   // Bit offsets of each byte inside the 40-bit frame
   localparam int OFF_HUM_INT  = 32;
   localparam int OFF_HUM_DEC  = 24;
   localparam int OFF_TEMP_INT = 16;
   localparam int OFF_TEMP_DEC = 8;
   localparam int OFF_CSUM     = 0;

   function automatic logic [7:0] frame_byte(
      input logic [39:0] f,
      input int          off
   );
      return f[off +: 8];
   endfunction

endpackage

// File: rtl/dht11_checksum.sv
// DHT11 frame checksum: low byte must equal the 8-bit sum of the
// four data bytes.
module dht11_checksum
   import dht11_pkg::*;
(
   input  logic [39:0] frame,
   output logic        ok
);

   logic [7:0] sum;

   always_comb begin
      sum = frame_byte(frame, OFF_HUM_INT)
          + frame_byte(frame, OFF_HUM_DEC)
          + frame_byte(frame, OFF_TEMP_INT)
          + frame_byte(frame, OFF_TEMP_DEC);
      ok  = (sum == frame_byte(frame, OFF_CSUM));
   end

endmodule

// File: rtl/dht11_poll_ctrl.sv
// DHT11 read sequencer: gap enforcement, timeout, checksum, retry.
// Define DHT11_AUTO_POLL_EN to add periodic self-triggered reads.
module dht11_poll_ctrl
   import dht11_pkg::*;
#(
   parameter int MIN_GAP_CYC = 100000000,
   parameter int TIMEOUT_CYC = 1500000,
   parameter int MAX_RETRY   = 2,
   parameter int POLL_CYC    = 250000000
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   output logic        rx_start,
   output logic        rx_abort,
   input  logic        rx_done,
   input  logic        rx_err,
   input  logic [39:0] rx_data,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic [1:0]  err_code,
   output logic [7:0]  hum_int,
   output logic [7:0]  hum_dec,
   output logic [7:0]  temp_int,
   output logic [7:0]  temp_dec
);

   localparam int GAP_W = $clog2(MIN_GAP_CYC + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC);
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP_CYC);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   state_t             state;
   state_t             nxt;
   logic [GAP_W-1:0]   gap_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [RTY_W-1:0]   rty_cnt;
   logic [39:0]        frame;
   logic               csum_ok;
   logic               gap_ok;
   logic               tmo_hit;
   logic               can_retry;
   logic               trig;

   assign gap_ok    = (gap_cnt == GAP_MAX);
   assign tmo_hit   = (tmo_cnt == TMO_LAST);
   assign can_retry = (rty_cnt < RTY_MAX);

`ifdef DHT11_AUTO_POLL_EN
   localparam int POLL_W = $clog2(POLL_CYC);

   logic [POLL_W-1:0] poll_cnt;
   logic              poll_tick;

   assign poll_tick = (poll_cnt == POLL_W'(POLL_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         poll_cnt <= '0;
      else if (poll_tick)
         poll_cnt <= '0;
      else
         poll_cnt <= poll_cnt + 1'b1;
   end

   // Poll ticks share the IDLE-only acceptance of host requests
   assign trig = req | poll_tick;
`else
   logic unused_poll;

   assign unused_poll = (POLL_CYC == 0);
   assign trig        = req;
`endif

   dht11_checksum u_csum (
      .frame (frame),
      .ok    (csum_ok)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (trig) nxt = GAP;
         GAP:     if (gap_ok) nxt = START;
         START:   nxt = WAIT;
         WAIT: begin
            if (rx_err)
               nxt = FAIL;
            else if (rx_done)
               nxt = CHECK;
            else if (tmo_hit)
               nxt = FAIL;
         end
         CHECK:   nxt = csum_ok ? IDLE : FAIL;
         FAIL:    nxt = can_retry ? GAP : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_start = 1'b0;
      rx_abort = 1'b0;
      done     = 1'b0;
      busy     = (state != IDLE);
      unique case (state)
         START:   rx_start = 1'b1;
         WAIT:    rx_abort = tmo_hit && !rx_err && !rx_done;
         CHECK:   done     = csum_ok;
         FAIL:    done     = !can_retry;
         default: ;
      endcase
   end

   // Counters and frame capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gap_cnt <= '0;
         tmo_cnt <= '0;
         rty_cnt <= '0;
         frame   <= '0;
      end else begin
         if (rx_start)
            gap_cnt <= '0;
         else if (!gap_ok)
            gap_cnt <= gap_cnt + 1'b1;

         if (state == START)
            tmo_cnt <= '0;
         else if (state == WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;

         if (state == IDLE && trig)
            rty_cnt <= '0;
         else if (state == FAIL && can_retry)
            rty_cnt <= rty_cnt + 1'b1;

         if (state == WAIT && rx_done)
            frame <= rx_data;
      end
   end

   // Result registers seen by the display/UART side
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_code <= ERR_OK;
         valid    <= 1'b0;
         hum_int  <= '0;
         hum_dec  <= '0;
         temp_int <= '0;
         temp_dec <= '0;
      end else begin
         if (state == WAIT) begin
            if (rx_err)
               err_code <= ERR_RX;
            else if (!rx_done && tmo_hit)
               err_code <= ERR_TMO;
         end
         if (state == CHECK) begin
            if (csum_ok) begin
               err_code <= ERR_OK;
               valid    <= 1'b1;
               hum_int  <= frame_byte(frame, OFF_HUM_INT);
               hum_dec  <= frame_byte(frame, OFF_HUM_DEC);
               temp_int <= frame_byte(frame, OFF_TEMP_INT);
               temp_dec <= frame_byte(frame, OFF_TEMP_DEC);
            end else begin
               err_code <= ERR_CRC;
            end
         end
      end
   end

endmodule
